approx_mult_pipe: RTL
=====================

Name: approx_mult_pipe

Overview:
- Parametrised, pipelined unsigned WIDTHxWIDTH approximate multiplier.
- The EXACT_ROWS most-significant partial-product rows (rows selected by the top bits of x) are summed exactly.
- The lower rows are truncated below column TRUNC_COL and pairwise OR-compressed.
- A per-transaction mode bit selects exact or approximate product; valid/ready streaming with full backpressure; sits in datapath accelerators as a drop-in multiplier stage.

Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH bits.
- EXACT_ROWS, 2, number of top partial-product rows computed exactly (0..WIDTH).
- TRUNC_COL, 8, approximate-row bits in columns below this are dropped (0..2*WIDTH-1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block accepts input this cycle
- x  in  WIDTH  multiplicand; row i = y & {WIDTH{x[i]}}, weight 2^i
- y  in  WIDTH  multiplier
- mode  in  1  1 = exact product, 0 = approximate
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- z  out  2*WIDTH  product
- z_mode  out  1  mode of the transaction carried in z

Behaviour:
- Reset (async, immediate): out_valid=0, z=0, z_mode=0, both stage valids cleared. in_ready=1 once reset is released.
- Row split: rows WIDTH-EXACT_ROWS..WIDTH-1 are exact; rows 0..WIDTH-EXACT_ROWS-1 are approximate.
- Approximate rows are paired (2k, 2k+1). For column c >= TRUNC_COL:
  - a = bit (c-2k) of row 2k; b = bit (c-2k-1) of row 2k+1; out-of-range bits = 0.
  - Contribution at weight 2^c is (a|b).
  - An unpaired last approximate row contributes its own bits at c >= TRUNC_COL.
- mode=1: z = x*y exactly.
- mode=0: z = exact-row sum + compressed approximate terms, truncated to 2*WIDTH bits (no overflow occurs for legal params).
- Pipeline: 2 stages.
  - S1 registers the exact-row sum, the compressed approximate vector (or the exact low-row sum in mode 1) and mode.
  - S2 performs the final add into the z register.
  - Latency is 2 cycles from accept to out_valid with no stall.
- Handshake:
  - Transfer occurs when valid && ready.
  - ready_s2 = !out_valid || out_ready; in_ready = !v_s1 || ready_s2.
  - Full throughput: 1 transaction per cycle.
- Stall: when out_valid && !out_ready, z and z_mode hold stable. S1 holds if occupied. At most 2 transactions are in flight. Results stay in order.
- Simultaneous accept and emit in the same cycle is legal and loses no data.
- x, y and mode are sampled only on accept.

Optional Feature:
- Macro: APPROX_MULT_ERR_MON_EN.
- Defined: adds ports err_z out 2*WIDTH and err_cnt out 16.
  - S2 also computes the exact product; err_z = exact - z is registered alongside z (0 in mode 1).
  - err_cnt increments on each output transfer with err_z != 0, saturates at 16'hFFFF, and resets to 0.
- Undefined: no extra ports or logic.

Decomposition:
- Package approx_mult_pkg:
  - MODE_APPROX=1'b0 and MODE_EXACT=1'b1 constants.
  - Default WIDTH/EXACT_ROWS/TRUNC_COL localparams.
  - Pure function approx_product(x, y, exact_rows, trunc_col, width) for use as the bench golden model.
- One sub-module, approx_pp_compress: combinational generator of the truncated, pair-OR'd approximate-row vector, instantiated in S1.

Test Plan:
- Defaults, x=255, y=255, mode=0 -> z=58944 after 2 cycles; same inputs with mode=1 -> z=65025, z_mode=1.
- x=192, y=1, either mode -> z=192; x=1, y=255, mode=0 -> z=0; mode=1 -> z=255.
- Back-to-back 4 transactions with out_ready=1 -> one result per cycle, in order, latency 2.
- out_ready held 0 for 4 cycles while offering 3 inputs -> 2 accepted, then in_ready=0; z stable; on release, outputs emerge in order with no loss or duplication.
- Assert rst while out_valid=1 -> out_valid and z go to 0 immediately; after release in_ready=1 and a new transaction x=3, y=5, mode=1 yields z=15.
- With APPROX_MULT_ERR_MON_EN: x=y=255, mode=0 -> err_z=6081, err_cnt 0->1; mode=1 -> err_z=0, err_cnt unchanged; randomized 10k vectors match approx_product.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared constants and a reference function for the approximate multiplier.
// Used by approx_mult_pipe; optional error monitor is APPROX_MULT_ERR_MON_EN.
package approx_mult_pkg;

    localparam logic MODE_APPROX = 1'b0;
    localparam logic MODE_EXACT  = 1'b1;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_EXACT_ROWS = 2;
    localparam int DEF_TRUNC_COL  = 8;

    // Approximate product for operands up to 32 bits; result in the low 2*width bits.
    function automatic logic [63:0] approx_product(
        input logic [31:0] x,
        input logic [31:0] y,
        input int          exact_rows,
        input int          trunc_col,
        input int          width
    );
        logic [63:0] acc;
        logic [63:0] a_vec;
        logic [63:0] b_vec;
        logic [63:0] keep;
        logic [63:0] yw;
        int          low;
        low  = width - exact_rows;
        yw   = {32'd0, y} & ~({64{1'b1}} << width);
        keep = {64{1'b1}} << trunc_col;
        acc  = '0;
        for (int i = 0; i < width; i++) begin
            if (i >= low && ((x >> i) & 32'd1) != 32'd0) begin
                acc = acc + (yw << i);
            end
        end
        for (int k = 0; 2 * k < low; k++) begin
            a_vec = (((x >> (2 * k)) & 32'd1) != 32'd0) ? (yw << (2 * k)) : 64'd0;
            b_vec = ((2 * k + 1 < low) && (((x >> (2 * k + 1)) & 32'd1) != 32'd0))
                    ? (yw << (2 * k + 1)) : 64'd0;
            acc   = acc + ((a_vec | b_vec) & keep);
        end
        if (width < 32) begin
            acc = acc & ~({64{1'b1}} << (2 * width));
        end
        return acc;
    endfunction

endpackage

// File: rtl/approx_pp_compress.sv
// Combinational truncated, pair-OR'd sum of the low (approximate) partial-product rows.
// Rows 2k and 2k+1 are OR'd column-wise, columns below TRUNC_COL dropped.
module approx_pp_compress
    import approx_mult_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int EXACT_ROWS = DEF_EXACT_ROWS,
    parameter int TRUNC_COL  = DEF_TRUNC_COL
) (
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0] approx_sum
);

    localparam int APPROX_ROWS = WIDTH - EXACT_ROWS;
    localparam int NUM_PAIRS   = (APPROX_ROWS + 1) / 2;
    localparam int PW          = 2 * WIDTH;
    localparam logic [PW-1:0] KEEP_MASK = {PW{1'b1}} << TRUNC_COL;

    logic [PW-1:0]              y_ext;
    logic [NUM_PAIRS:0][PW-1:0] acc;
    logic                       unused_x;

    assign y_ext    = {{WIDTH{1'b0}}, y};
    assign acc[0]   = '0;
    // Exact rows are handled by the caller; only the low bits of x matter here.
    assign unused_x = ^x;

    for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_pair
        logic [PW-1:0] a_vec;
        logic [PW-1:0] b_vec;
        assign a_vec = x[2*gi] ? (y_ext << (2 * gi)) : '0;
        if (2 * gi + 1 < APPROX_ROWS) begin : g_b
            assign b_vec = x[2*gi+1] ? (y_ext << (2 * gi + 1)) : '0;
        end else begin : g_nob
            assign b_vec = '0;
        end
        assign acc[gi+1] = acc[gi] + ((a_vec | b_vec) & KEEP_MASK);
    end

    assign approx_sum = acc[NUM_PAIRS];

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage valid/ready approximate multiplier; mode selects exact or approximate.
// Optional error monitor (err_z, err_cnt) enabled by APPROX_MULT_ERR_MON_EN.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int EXACT_ROWS = DEF_EXACT_ROWS,
    parameter int TRUNC_COL  = DEF_TRUNC_COL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z,
    output logic               z_mode
`ifdef APPROX_MULT_ERR_MON_EN
    ,
    output logic [2*WIDTH-1:0] err_z,
    output logic [15:0]        err_cnt
`endif
);

    localparam int PW       = 2 * WIDTH;
    localparam int LOW_ROWS = WIDTH - EXACT_ROWS;
    localparam logic [WIDTH-1:0] HI_MASK = {WIDTH{1'b1}} << LOW_ROWS;

    logic [PW-1:0] hi_sum;
    logic [PW-1:0] lo_exact;
    logic [PW-1:0] lo_approx;
    logic          ready_s2;

    logic          v_s1_reg;
    logic [PW-1:0] hi_s1_reg;
    logic [PW-1:0] lo_s1_reg;
    logic          mode_s1_reg;

    logic          out_valid_reg;
    logic [PW-1:0] z_reg;
    logic          z_mode_reg;
    logic [PW-1:0] z_next;

    // Masking x selects whole rows, so each product is a plain row sum.
    assign hi_sum   = PW'(x & HI_MASK) * PW'(y);
    assign lo_exact = PW'(x & ~HI_MASK) * PW'(y);

    approx_pp_compress #(
        .WIDTH      (WIDTH),
        .EXACT_ROWS (EXACT_ROWS),
        .TRUNC_COL  (TRUNC_COL)
    ) u_compress (
        .x          (x),
        .y          (y),
        .approx_sum (lo_approx)
    );

    assign ready_s2 = !out_valid_reg || out_ready;
    assign in_ready = !v_s1_reg || ready_s2;
    assign z_next   = hi_s1_reg + lo_s1_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_s1_reg    <= 1'b0;
            hi_s1_reg   <= '0;
            lo_s1_reg   <= '0;
            mode_s1_reg <= MODE_APPROX;
        end else if (in_ready) begin
            v_s1_reg <= in_valid;
            if (in_valid) begin
                hi_s1_reg   <= hi_sum;
                lo_s1_reg   <= (mode == MODE_EXACT) ? lo_exact : lo_approx;
                mode_s1_reg <= mode;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            z_reg         <= '0;
            z_mode_reg    <= MODE_APPROX;
        end else if (ready_s2) begin
            out_valid_reg <= v_s1_reg;
            if (v_s1_reg) begin
                z_reg      <= z_next;
                z_mode_reg <= mode_s1_reg;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign z         = z_reg;
    assign z_mode    = z_mode_reg;

`ifdef APPROX_MULT_ERR_MON_EN
    logic [WIDTH-1:0] x_s1_reg;
    logic [WIDTH-1:0] y_s1_reg;
    logic [PW-1:0]    exact_s2;
    logic [PW-1:0]    err_next;
    logic [PW-1:0]    err_z_reg;
    logic [15:0]      err_cnt_reg;

    assign exact_s2 = PW'(x_s1_reg) * PW'(y_s1_reg);
    assign err_next = (mode_s1_reg == MODE_EXACT) ? '0 : (exact_s2 - z_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_s1_reg <= '0;
            y_s1_reg <= '0;
        end else if (in_ready && in_valid) begin
            x_s1_reg <= x;
            y_s1_reg <= y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_z_reg   <= '0;
            err_cnt_reg <= '0;
        end else begin
            // Count against the result leaving now, before S2 may reload.
            if (out_valid_reg && out_ready && err_z_reg != '0 && err_cnt_reg != 16'hFFFF) begin
                err_cnt_reg <= err_cnt_reg + 16'd1;
            end
            if (ready_s2 && v_s1_reg) begin
                err_z_reg <= err_next;
            end
        end
    end

    assign err_z   = err_z_reg;
    assign err_cnt = err_cnt_reg;
`endif

endmodule
